data_mem_ctrl: RTL and testbench

- Sits directly downstream of the datapath, between its load/store outputs (ALU_Result as address, WriteData, MemWrite) and an external variable-latency data SRAM.
- Converts each single-cycle load/store into a req/ack handshake with the SRAM.
- Freezes the processor with Stall until the access completes.
- Returns ReadData to the datapath and flags misaligned or timed-out accesses.

---
 rtl/mips_pkg.sv | 17 +
 rtl/access_timer.sv | 27 ++
 rtl/data_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory controller slice.
//   state_t      : controller FSM encoding
//   DEF_TIMEOUT  : default SRAM wait budget, in cycles
//   RD_ERR_FILL  : value returned to the datapath by a load that timed out
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_BUSY = 2'd1,
    WR_BUSY = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int          DEF_TIMEOUT = 255;
  localparam logic [31:0] RD_ERR_FILL = 32'hFFFF_FFFF;

endpackage

// File: rtl/access_timer.sv
// 8-bit wait counter for an outstanding SRAM access.
//   clk, rst : clock, async active-high reset
//   clr      : zero the count (wins over en)
//   en       : count this cycle
//   expired  : this is the TIMEOUT-th counted cycle
module access_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 8'd1;
  end

  // The first busy cycle sees count==0, so the TIMEOUT-th sees TIMEOUT-1.
  assign expired = en && (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_ctrl.sv
// Turns single-cycle datapath loads/stores into a req/ack SRAM handshake,
// stalling the core until the access finishes.
//   clk, rst          : clock, async active-high reset
//   MemRead/MemWrite  : access request from control (write wins if both)
//   Addr, WriteData   : byte address and store data from the datapath
//   ReadData          : last completed load result (held across stores)
//   Stall             : combinational freeze of PC / register-file writes
//   Misalign_Err      : 1-cycle pulse, access dropped for Addr[1:0]!=0
//   Timeout_Err       : 1-cycle pulse, SRAM never acked within TIMEOUT
//   mem_req/we/addr/wdata : registered SRAM request, stable while mem_req=1
//   mem_rdata, mem_ack    : SRAM response, ack is one cycle per request
module data_mem_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [WIDTH-1:0]      WriteData,
  output logic [WIDTH-1:0]      ReadData,
  output logic                  Stall,
  output logic                  Misalign_Err,
  output logic                  Timeout_Err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_wdata,
  input  logic [WIDTH-1:0]      mem_rdata,
  input  logic                  mem_ack
);

  state_t                  state, state_nx;
  logic [WIDTH-1:0]        rdata_nx, wdata_nx;
  logic [ADDR_WIDTH-1:0]   addr_nx;
  logic                    req_nx, we_nx, mis_nx, to_nx, stall_c;
  logic                    busy, expired;

  assign busy = (state == RD_BUSY) || (state == WR_BUSY);

  // Ack completes an access and clears the timer; expiry clears it too so a
  // later access always starts from zero.
  access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (!busy || mem_ack || expired),
    .en      (busy),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ReadData     <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      Misalign_Err <= 1'b0;
      Timeout_Err  <= 1'b0;
    end else begin
      state        <= state_nx;
      ReadData     <= rdata_nx;
      mem_req      <= req_nx;
      mem_we       <= we_nx;
      mem_addr     <= addr_nx;
      mem_wdata    <= wdata_nx;
      Misalign_Err <= mis_nx;
      Timeout_Err  <= to_nx;
    end
  end

  always_comb begin
    state_nx = state;
    rdata_nx = ReadData;
    req_nx   = mem_req;
    we_nx    = mem_we;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
    mis_nx   = 1'b0;
    to_nx    = 1'b0;
    stall_c  = 1'b0;
    case (state)
      IDLE: begin
        if (MemRead || MemWrite) begin
          if (Addr[1:0] == 2'b00) begin
            stall_c  = 1'b1;
            req_nx   = 1'b1;
            we_nx    = MemWrite;
            addr_nx  = Addr;
            wdata_nx = WriteData;
            state_nx = MemWrite ? WR_BUSY : RD_BUSY;
          end else begin
            // Dropped without stalling; the core moves on with ReadData=0.
            mis_nx   = 1'b1;
            rdata_nx = '0;
          end
        end
      end
      RD_BUSY, WR_BUSY: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          req_nx   = 1'b0;
          state_nx = DONE;
          if (state == RD_BUSY) rdata_nx = mem_rdata;
        end else if (expired) begin
          req_nx   = 1'b0;
          to_nx    = 1'b1;
          state_nx = DONE;
          if (state == RD_BUSY) rdata_nx = WIDTH'(RD_ERR_FILL);
        end
      end
      // Control still shows the finished instruction here; returning to IDLE
      // without looking at it is what prevents a re-issue.
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Reset must force every output low, including this combinational one.
  assign Stall = stall_c && !rst;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: the driver issues instructions and plays the SRAM,
// pushing the expected per-instruction outcome; the monitor measures what
// the controller actually did and compares when each instruction retires.
module tb_data_mem_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0, rst = 1'b1;
  logic        MemRead = 1'b0, MemWrite = 1'b0, mem_ack = 1'b0;
  logic [31:0] Addr = '0, WriteData = '0, mem_rdata = '0;
  logic [31:0] ReadData, mem_addr, mem_wdata;
  logic        Stall, Misalign_Err, Timeout_Err, mem_req, mem_we;

  always #5 clk = ~clk;

  data_mem_ctrl #(.WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall),
    .Misalign_Err(Misalign_Err), .Timeout_Err(Timeout_Err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {
    logic [31:0] rdata, addr, wdata;
    logic        we;
    int          stall, req, mis, to;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, errs = 0;
  logic [31:0] model_rd = '0;
  logic        flush = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // ---------------- monitor ----------------
  int          phase = 0, st_c, rq_c, mis_c, to_c, unstable, rd_chg, gap_bad;
  logic        got_req, got_rd, o_we, act;
  logic [31:0] o_rd, o_addr, o_wd;

  task automatic finalize();
    exp_t e;
    if (q.size() == 0) begin
      chk("scoreboard_underflow", 32'd1, 32'd0);
      return;
    end
    e = q.pop_front();
    chk("stall_cycles", st_c, e.stall);
    chk("req_cycles", rq_c, e.req);
    chk("misalign_pulse", mis_c, e.mis);
    chk("timeout_pulse", to_c, e.to);
    chk("read_data", o_rd, e.rdata);
    chk("read_data_held", rd_chg, 0);
    chk("idle_quiet", gap_bad, 0);
    if (e.req > 0) begin
      chk("mem_we", 32'(o_we), 32'(e.we));
      chk("mem_addr", o_addr, e.addr);
      chk("mem_wdata", o_wd, e.wdata);
      chk("req_stable", unstable, 0);
    end
  endtask

  always @(negedge clk) begin
    if (rst) phase = 0;
    else begin
      act = MemRead | MemWrite;
      if (phase == 2 && (act || flush)) begin
        finalize();
        phase = 0;
      end
      if (phase == 0 && act) begin
        st_c = 0; rq_c = 0; mis_c = 0; to_c = 0; unstable = 0;
        rd_chg = 0; gap_bad = 0; got_req = 1'b0; got_rd = 1'b0;
        phase = 1;
      end
      if (phase == 1) begin
        if (Stall) st_c++;
        if (Misalign_Err) mis_c++;
        if (Timeout_Err) to_c++;
        if (mem_req) begin
          rq_c++;
          if (!got_req) begin
            o_we = mem_we; o_addr = mem_addr; o_wd = mem_wdata; got_req = 1'b1;
          end else if (mem_we !== o_we || mem_addr !== o_addr || mem_wdata !== o_wd)
            unstable = 1;
        end
        if (!Stall) phase = 2;
      end else if (phase == 2) begin
        if (Misalign_Err) mis_c++;
        if (Timeout_Err) to_c++;
        if (Stall || mem_req) gap_bad = 1;
        if (!got_rd) begin
          o_rd = ReadData; got_rd = 1'b1;
        end else if (ReadData !== o_rd) rd_chg = 1;
      end
    end
  end

  // ---------------- driver + SRAM model ----------------
  // d = SRAM wait cycles before ack (-1: never acks); late = idle cycle index
  // at which a stray ack is injected (>= gap: none).
  task automatic do_instr(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input int d,
                          input logic [31:0] rdv, input int gap, input int late);
    exp_t e;
    int   k, n;
    logic last, fin;
    e.we = wr; e.addr = a; e.wdata = wd; e.mis = 0; e.to = 0;
    if (a[1:0] != 2'b00) begin
      e.stall = 0; e.req = 0; e.mis = 1; model_rd = '0;
    end else if (d >= 0 && d < TO) begin
      e.stall = d + 2; e.req = d + 1;
      if (rd && !wr) model_rd = rdv;
    end else begin
      e.stall = TO + 1; e.req = TO; e.to = 1;
      if (rd && !wr) model_rd = 32'hFFFF_FFFF;
    end
    e.rdata = model_rd;
    q.push_back(e);

    MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd;
    k = 0; n = 0; fin = 1'b0;
    while (!fin) begin
      mem_ack   = mem_req && (k == d);
      mem_rdata = mem_ack ? rdv : $urandom();
      #1;
      last = !Stall;
      if (mem_req) k++;
      @(posedge clk); #1;
      n++;
      if (last) fin = 1'b1;
      else if (n > TO + 20) begin
        chk("instr_cycle_bound", 32'(n), 32'd0);
        fin = 1'b1;
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b0;
    for (int g = 0; g < gap; g++) begin
      mem_ack   = (g == late);
      mem_rdata = $urandom();
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    logic        r_rd, r_wr;
    logic [31:0] a;
    int          r, d;

    #12;
    chk("rst_ReadData", ReadData, 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_Stall", 32'(Stall), 32'h0);
    chk("rst_errs", {30'h0, Misalign_Err, Timeout_Err}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    do_instr(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h1234_5678, 2, 9);     // fast load
    do_instr(1'b0, 1'b1, 32'h20, 32'hCAFE_F00D, 4, 32'h0, 2, 9);     // slow store
    do_instr(1'b1, 1'b0, 32'h13, 32'h0, 0, 32'h0, 2, 9);             // misaligned
    do_instr(1'b1, 1'b0, 32'h30, 32'h0, -1, 32'h0, 4, 1);            // timeout + late ack
    do_instr(1'b1, 1'b1, 32'h40, 32'h55AA_33CC, 1, 32'hDEAD_0000, 2, 9); // write wins
    do_instr(1'b1, 1'b0, 32'h50, 32'h0, 0, 32'hA5A5_0001, 1, 9);

    // Reset while a load is outstanding.
    MemRead = 1'b1; Addr = 32'h10;
    @(posedge clk); #1;
    chk("pre_rst_mem_req", 32'(mem_req), 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_mem_req", 32'(mem_req), 32'h0);
    chk("midrst_ReadData", ReadData, 32'h0);
    chk("midrst_Stall", 32'(Stall), 32'h0);
    chk("midrst_mem_we", 32'(mem_we), 32'h0);
    chk("midrst_mem_addr", mem_addr, 32'h0);
    MemRead = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; model_rd = '0;
    @(posedge clk); #1;
    do_instr(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h0BAD_F00D, 2, 9);

    for (int i = 0; i < 40; i++) begin
      r_rd = 1'($urandom_range(0, 1));
      r_wr = r_rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      a = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
      r = $urandom_range(0, 11);
      d = (r == 11) ? -1 : r;
      do_instr(r_rd, r_wr, a, $urandom(), d, $urandom(),
               $urandom_range(1, 3), $urandom_range(0, 4));
    end

    flush = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end

endmodule
